mod13_down_cntr: RTL and testbench

Loadable mod-13 down counter, the counting-down counterpart to the team's mod-13 up counter, used wherever a countdown from 12 to 0 is needed. It adds parallel load, count enable, a periodic or one-shot mode, a one-cycle borrow pulse at terminal count, and a small run-control FSM. Its borrow output can be cascaded into the enable of a following stage or used as a tick for timers built on the counter family.

---
 rtl/mod_cntr_pkg.sv | 20 ++
 rtl/mod13_down_cntr.sv | 82 ++++++++
 tb/tb_mod13_down_cntr.sv | 162 ++++++++++++++++
 3 files changed

// File: rtl/mod_cntr_pkg.sv
// Shared definitions for the mod-N counter family: constants, run-control
// state encoding and the load-value clamp.
package mod_cntr_pkg;

  localparam int MODULUS_13 = 13;
  localparam int W4         = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } cntr_state_e;

  // Saturate a requested load value to the top count (modulus - 1).
  function automatic int unsigned clamp_mod(input int unsigned v,
                                            input int unsigned modulus);
    return (v > modulus - 1) ? (modulus - 1) : v;
  endfunction

endpackage

// File: rtl/mod13_down_cntr.sv
// Loadable mod-13 down counter with periodic / one-shot modes, a registered
// one-cycle borrow pulse at terminal count and IDLE/RUN/DONE run control.
// Priority per edge: reset low > load > en. All outputs are registered.
module mod13_down_cntr
  import mod_cntr_pkg::*;
#(
  parameter int MODULUS = MODULUS_13,
  parameter int WIDTH   = W4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  input  logic             mode,
  output logic [WIDTH-1:0] Q,
  output logic             borrow,
  output logic             busy,
  output logic             done
);

  localparam logic [WIDTH-1:0] QMAX = WIDTH'(MODULUS - 1);
  localparam logic [WIDTH-1:0] ONE  = WIDTH'(1);

  cntr_state_e      state_q, state_d;
  logic [WIDTH-1:0] q_q, q_d;
  logic             borrow_q, borrow_d;
  logic             busy_q, done_q;

  // Next count, borrow and run state; load overrides counting in any state.
  always_comb begin
    state_d  = state_q;
    q_d      = q_q;
    borrow_d = 1'b0;
    if (load) begin
      q_d     = WIDTH'(clamp_mod(32'(load_val), MODULUS));
      state_d = RUN;
    end else begin
      case (state_q)
        RUN: begin
          if (en) begin
            if (q_q == '0) begin
              borrow_d = 1'b1;
              // mode only matters here, at the terminal-count edge
              if (mode) state_d = DONE;
              else      q_d     = QMAX;
            end else begin
              q_d = q_q - ONE;
            end
          end
        end
        IDLE:    ;
        DONE:    ;
        default: state_d = IDLE;
      endcase
    end
  end

  // State and output registers; busy/done are registered from next state so
  // they line up with Q and borrow.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q  <= IDLE;
      q_q      <= QMAX;
      borrow_q <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      q_q      <= q_d;
      borrow_q <= borrow_d;
      busy_q   <= (state_d == RUN);
      done_q   <= (state_d == DONE);
    end
  end

  assign Q      = q_q;
  assign borrow = borrow_q;
  assign busy   = busy_q;
  assign done   = done_q;

endmodule

// File: tb/tb_mod13_down_cntr.sv
// Directed bench for mod13_down_cntr: a vector table for reset, periodic and
// one-shot sequences, plus hand-written multi-cycle corner cases.
module tb_mod13_down_cntr;

  logic       clk = 1'b0;
  logic       reset, en, load, mode;
  logic [3:0] load_val;
  logic [3:0] Q;
  logic       borrow, busy, done;

  int checks   = 0;
  int failures = 0;

  mod13_down_cntr #(.MODULUS(13), .WIDTH(4)) dut (
    .clk(clk), .reset(reset), .en(en), .load(load), .load_val(load_val),
    .mode(mode), .Q(Q), .borrow(borrow), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       rst_n;
    logic       ld;
    logic [3:0] lv;
    logic       en;
    logic       md;
    logic [3:0] q;
    logic       b;
    logic       bz;
    logic       dn;
  } vec_t;

  vec_t vt[$];

  function automatic vec_t mk(logic rst_n, logic ld, logic [3:0] lv, logic e,
                              logic md, logic [3:0] q, logic b, logic bz,
                              logic dn);
    vec_t v;
    v.rst_n = rst_n; v.ld = ld; v.lv = lv; v.en = e; v.md = md;
    v.q = q; v.b = b; v.bz = bz; v.dn = dn;
    return v;
  endfunction

  // Drive inputs on the falling edge, then sample 1 time unit after the
  // following rising edge.
  task automatic step(input logic rst_n, input logic ld, input logic [3:0] lv,
                      input logic e, input logic md);
    @(negedge clk);
    reset = rst_n; load = ld; load_val = lv; en = e; mode = md;
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [3:0] eq, input logic eb,
                       input logic ebz, input logic edn);
    checks++;
    if (Q !== eq) begin
      failures++;
      $display("FAIL %s Q: got %0d expected %0d", tag, Q, eq);
    end
    checks++;
    if (borrow !== eb) begin
      failures++;
      $display("FAIL %s borrow: got %b expected %b", tag, borrow, eb);
    end
    checks++;
    if (busy !== ebz) begin
      failures++;
      $display("FAIL %s busy: got %b expected %b", tag, busy, ebz);
    end
    checks++;
    if (done !== edn) begin
      failures++;
      $display("FAIL %s done: got %b expected %b", tag, done, edn);
    end
  endtask

  initial begin
    int nborrow;
    logic [3:0] eq;
    reset = 1'b0; en = 1'b0; load = 1'b0; load_val = '0; mode = 1'b0;

    // rst_n ld lv en md | Q b busy done
    // reset for two cycles, then en-only must stay in IDLE at 12
    vt.push_back(mk(0, 0, 0, 0, 0, 12, 0, 0, 0));
    vt.push_back(mk(0, 0, 0, 1, 0, 12, 0, 0, 0));
    vt.push_back(mk(1, 0, 0, 1, 0, 12, 0, 0, 0));
    vt.push_back(mk(1, 0, 0, 1, 0, 12, 0, 0, 0));
    vt.push_back(mk(1, 0, 0, 1, 0, 12, 0, 0, 0));
    // periodic from 5: 5,4,3,2,1,0,12(borrow),11
    vt.push_back(mk(1, 1, 5, 1, 0,  5, 0, 1, 0));
    vt.push_back(mk(1, 0, 0, 1, 0,  4, 0, 1, 0));
    vt.push_back(mk(1, 0, 0, 1, 0,  3, 0, 1, 0));
    vt.push_back(mk(1, 0, 0, 1, 0,  2, 0, 1, 0));
    vt.push_back(mk(1, 0, 0, 1, 0,  1, 0, 1, 0));
    vt.push_back(mk(1, 0, 0, 1, 0,  0, 0, 1, 0));
    vt.push_back(mk(1, 0, 0, 1, 0, 12, 1, 1, 0));
    vt.push_back(mk(1, 0, 0, 1, 0, 11, 0, 1, 0));
    vt.push_back(mk(1, 0, 0, 0, 0, 11, 0, 1, 0));
    // one-shot from 3: 3,2,1,0, then borrow once and DONE holds 0
    vt.push_back(mk(1, 1, 3, 0, 1,  3, 0, 1, 0));
    vt.push_back(mk(1, 0, 0, 1, 1,  2, 0, 1, 0));
    vt.push_back(mk(1, 0, 0, 1, 1,  1, 0, 1, 0));
    vt.push_back(mk(1, 0, 0, 1, 1,  0, 0, 1, 0));
    vt.push_back(mk(1, 0, 0, 1, 1,  0, 1, 0, 1));
    vt.push_back(mk(1, 0, 0, 1, 1,  0, 0, 0, 1));
    vt.push_back(mk(1, 0, 0, 1, 0,  0, 0, 0, 1));
    // clamp: 13 loads 12
    vt.push_back(mk(1, 1, 13, 0, 0, 12, 0, 1, 0));

    foreach (vt[i]) begin
      step(vt[i].rst_n, vt[i].ld, vt[i].lv, vt[i].en, vt[i].md);
      check($sformatf("vec%0d", i), vt[i].q, vt[i].b, vt[i].bz, vt[i].dn);
    end

    // load 15 clamps to 12, then a full periodic cycle of 13 enabled edges
    step(1, 1, 15, 0, 0);
    check("load15", 12, 0, 1, 0);
    nborrow = 0;
    for (int k = 1; k <= 13; k++) begin
      step(1, 0, 0, 1, 0);
      eq = (k <= 12) ? 4'(12 - k) : 4'd12;
      if (borrow) nborrow++;
      check($sformatf("wrap%0d", k), eq, (k == 13), 1, 0);
    end
    checks++;
    if (nborrow != 1) begin
      failures++;
      $display("FAIL wrap_borrow_count: got %0d expected 1", nborrow);
    end

    // load wins over terminal count: no borrow, Q = 7
    step(1, 1, 1, 0, 0);
    check("tc_pre1", 1, 0, 1, 0);
    step(1, 0, 0, 1, 0);
    check("tc_pre0", 0, 0, 1, 0);
    step(1, 1, 7, 1, 0);
    check("tc_load7", 7, 0, 1, 0);
    step(1, 0, 0, 0, 0);
    check("tc_hold", 7, 0, 1, 0);

    // load 0 then enable: borrow on the first enabled edge
    step(1, 1, 0, 0, 0);
    check("ld0", 0, 0, 1, 0);
    step(1, 0, 0, 1, 0);
    check("ld0_en", 12, 1, 1, 0);

    // reset mid-count beats load and en
    step(1, 1, 9, 0, 0);
    check("mid_ld9", 9, 0, 1, 0);
    for (int k = 0; k < 3; k++) step(1, 0, 0, 1, 0);
    check("mid_q6", 6, 0, 1, 0);
    step(0, 1, 3, 1, 0);
    check("mid_reset", 12, 0, 0, 0);
    step(1, 0, 0, 1, 0);
    check("post_reset_idle", 12, 0, 0, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
